fd_pipe_reg: RTL and testbench

- F/D pipeline register of the P7 five-stage MIPS core; sits between the fetch stage (PC/IM) and the decode stage.
- Performs F-stage exception detection: instruction-fetch address error (AdEL) on the F-stage PC.
- Forwards PC, instruction, fetch-side ExcCode and branch-delay flag to decode; D-stage exception logic merges RI onto that ExcCode.
- Handles stall (hold), exception/interrupt flush (Req), and ERET flush.

---
 rtl/fd_pipe_reg.sv | 68 ++++++
 tb/tb_fd_pipe_reg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// fd_pipe_reg: F/D pipeline register with fetch address-error (AdEL) detection,
// stall hold, exception/interrupt flush to a handler bubble and ERET squash.
module fd_pipe_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic [31:0] Instr_F,
  input  logic        BD_F,
  input  logic        Stall,
  input  logic        Req,
  input  logic        EretFlush,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D,
  output logic        Valid_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic adel_f;

  assign adel_f = (PC_F[1:0] != 2'b00) || (PC_F < IM_LO) || (PC_F > IM_HI);

  // Req outranks Stall so a flush is never lost while the hazard unit holds F/D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_D      <= PC_RESET;
      Instr_D   <= 32'd0;
      ExcCode_D <= EXC_NONE;
      BD_D      <= 1'b0;
      Valid_D   <= 1'b0;
    end else if (Req) begin
      PC_D      <= PC_HANDLER;
      Instr_D   <= 32'd0;
      ExcCode_D <= EXC_NONE;
      BD_D      <= 1'b0;
      Valid_D   <= 1'b0;
    end else if (Stall) begin
      PC_D      <= PC_D;
      Instr_D   <= Instr_D;
      ExcCode_D <= ExcCode_D;
      BD_D      <= BD_D;
      Valid_D   <= Valid_D;
    end else if (EretFlush) begin
      PC_D      <= PC_F;
      Instr_D   <= 32'd0;
      ExcCode_D <= EXC_NONE;
      BD_D      <= 1'b0;
      Valid_D   <= 1'b0;
    end else begin
      PC_D      <= PC_F;
      Instr_D   <= adel_f ? 32'd0 : Instr_F;
      ExcCode_D <= adel_f ? EXC_ADEL : EXC_NONE;
      BD_D      <= BD_F;
      Valid_D   <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// tb_fd_pipe_reg: directed-vector self-checking bench for fd_pipe_reg.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic        BD_F;
  logic        Stall;
  logic        Req;
  logic        EretFlush;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;
  logic        Valid_D;

  int vectors     = 0;
  int miscompares = 0;

  fd_pipe_reg dut (
    .clk       (clk),
    .reset     (reset),
    .PC_F      (PC_F),
    .Instr_F   (Instr_F),
    .BD_F      (BD_F),
    .Stall     (Stall),
    .Req       (Req),
    .EretFlush (EretFlush),
    .PC_D      (PC_D),
    .Instr_D   (Instr_D),
    .ExcCode_D (ExcCode_D),
    .BD_D      (BD_D),
    .Valid_D   (Valid_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [4:0] exc, input logic bd, input logic vld);
    check({tag, ".pc"},    PC_D,      pc);
    check({tag, ".instr"}, Instr_D,   ins);
    check({tag, ".exc"},   {27'd0, ExcCode_D}, {27'd0, exc});
    check({tag, ".bd"},    {31'd0, BD_D},      {31'd0, bd});
    check({tag, ".valid"}, {31'd0, Valid_D},   {31'd0, vld});
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    PC_F = pc; Instr_F = ins; BD_F = bd;
    tick();
  endtask

  initial begin
    reset = 1'b1; PC_F = 32'h3010; Instr_F = 32'hDEAD_BEEF; BD_F = 1'b1;
    Stall = 1'b0; Req = 1'b0; EretFlush = 1'b0;
    tick(); tick();
    check_all("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;

    fetch(32'h3004, 32'h2401_0005, 1'b1);
    check_all("capture", 32'h3004, 32'h2401_0005, 5'd0, 1'b1, 1'b1);

    // Asynchronous reset between edges
    PC_F = 32'h3010; Instr_F = 32'h1111_1111;
    #2 reset = 1'b1;
    #1 check_all("async_rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    fetch(32'h3002, 32'h1234_5678, 1'b0);
    check_all("adel_align", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
    fetch(32'h7000, 32'h1234_5678, 1'b0);
    check_all("adel_hi", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
    fetch(32'h2FFC, 32'h1234_5678, 1'b1);
    check_all("adel_lo", 32'h2FFC, 32'h0, 5'd4, 1'b1, 1'b1);
    fetch(32'h6FFC, 32'hAABB_CCDD, 1'b0);
    check_all("im_hi_ok", 32'h6FFC, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b1);
    fetch(32'h3000, 32'h0BAD_F00D, 1'b0);
    check_all("im_lo_ok", 32'h3000, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b1);

    fetch(32'h3008, 32'h1111_2222, 1'b0);
    check_all("pre_stall", 32'h3008, 32'h1111_2222, 5'd0, 1'b0, 1'b1);
    Stall = 1'b1; PC_F = 32'h3001; Instr_F = 32'h9999_9999; BD_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall_hold", 32'h3008, 32'h1111_2222, 5'd0, 1'b0, 1'b1);
    end
    Stall = 1'b0;
    tick();
    check_all("stall_release", 32'h3001, 32'h0, 5'd4, 1'b1, 1'b1);

    // Stall also blocks an ERET squash
    fetch(32'h3020, 32'h5555_AAAA, 1'b0);
    Stall = 1'b1; EretFlush = 1'b1; PC_F = 32'h3024;
    tick();
    check_all("stall_eret", 32'h3020, 32'h5555_AAAA, 5'd0, 1'b0, 1'b1);
    EretFlush = 1'b0;

    Req = 1'b1; BD_F = 1'b1; PC_F = 32'h3030; Instr_F = 32'h7777_7777;
    tick();
    check_all("req_stall", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    Stall = 1'b0; EretFlush = 1'b1; PC_F = 32'h3002;
    tick();
    check_all("req_repeat", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    Req = 1'b0; EretFlush = 1'b0;

    EretFlush = 1'b1;
    fetch(32'h300C, 32'h0000_0020, 1'b1);
    check_all("eret", 32'h300C, 32'h0, 5'd0, 1'b0, 1'b0);
    EretFlush = 1'b1;
    fetch(32'h7000, 32'h0000_0020, 1'b0);
    check_all("eret_fault", 32'h7000, 32'h0, 5'd0, 1'b0, 1'b0);
    EretFlush = 1'b0;
    fetch(32'h3100, 32'h0000_0005, 1'b0);
    check_all("post_eret", 32'h3100, 32'h0000_0005, 5'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
